// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: LSL/LSR/ASR/ROL, up to STEP bits per clock.
// Optional sticky LSL overflow flag on out_ovf when SHIFT_OVF_EN is defined.
module shift_unit_seq #(
   parameter  int WIDTH = 8,
   parameter  int STEP  = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SHIFT_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_shift;
   logic [1:0]       r_mode;
   logic [AMT_W-1:0] r_rem;
   logic [AMT_W-1:0] w_k;
   logic [AMT_W-1:0] w_kinv;
   logic             w_accept;
   logic             w_shifting;

   assign w_accept   = in_valid && (r_state == S_IDLE);
   assign w_shifting = (r_state == S_SHIFT);

   // WIDTH is a power of two, so WIDTH-k wraps cleanly in AMT_W bits
   always_comb begin
      w_k    = (r_rem < STEP_A) ? r_rem : STEP_A;
      w_kinv = '0 - w_k;
   end

   always_comb begin
      w_shift = r_data;
      unique case (r_mode)
         2'b00: w_shift = r_data << w_k;
         2'b01: w_shift = r_data >> w_k;
         2'b10: w_shift = $signed(r_data) >>> w_k;
         2'b11: w_shift = (r_data << w_k) | (r_data >> w_kinv);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_next = (in_amt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_rem == w_k) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_mode <= '0;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_data <= in_data;
         r_mode <= in_mode;
         r_rem  <= in_amt;
      end else if (w_shifting) begin
         r_data <= w_shift;
         r_rem  <= r_rem - w_k;
      end
   end

`ifdef SHIFT_OVF_EN
   logic r_ovf;
   logic w_lost;

   // top k bits of the working value leave through the MSB this cycle
   assign w_lost = (r_mode == 2'b00) && (w_k != '0)
                   && ((r_data >> w_kinv) != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_shifting && w_lost) begin
         r_ovf <= 1'b1;
      end
   end

   assign out_ovf = r_ovf;
`endif

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out_data  = r_data;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: STEP=1 and STEP=2 instances, table vectors,
// random ops against a whole-amount model, backpressure and reset abort.
module tb_shift_unit_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid0;
   logic       in_valid1;
   logic       in_ready0;
   logic       in_ready1;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic [1:0] in_mode;
   logic       out_valid0;
   logic       out_valid1;
   logic       out_ready;
   logic [7:0] out_data0;
   logic [7:0] out_data1;
   logic       out_ovf0;
   logic       out_ovf1;

   int total;
   int bad;

   shift_unit_seq #(.WIDTH(8), .STEP(1)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_data  (out_data0)
`ifdef SHIFT_OVF_EN
      ,
      .out_ovf   (out_ovf0)
`endif
   );

   shift_unit_seq #(.WIDTH(8), .STEP(2)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_data  (out_data1)
`ifdef SHIFT_OVF_EN
      ,
      .out_ovf   (out_ovf1)
`endif
   );

`ifndef SHIFT_OVF_EN
   assign out_ovf0 = 1'b0;
   assign out_ovf1 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [2:0] amt;
      logic [1:0] mode;
      logic [7:0] exp;
      int         edges;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       ovf;
      int         edges;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[14];

   function automatic logic rdy(input int sel);
      return (sel == 1) ? in_ready1 : in_ready0;
   endfunction

   function automatic logic ov(input int sel);
      return (sel == 1) ? out_valid1 : out_valid0;
   endfunction

   function automatic logic [7:0] od(input int sel);
      return (sel == 1) ? out_data1 : out_data0;
   endfunction

   function automatic logic oo(input int sel);
      return (sel == 1) ? out_ovf1 : out_ovf0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Whole-amount reference, independent of the per-cycle stepping
   task automatic model(input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, output logic [7:0] r,
                        output logic o);
      logic [15:0] w;
      o = 1'b0;
      case (m)
         2'b00: begin
            w = {8'h00, d} << a;
            r = w[7:0];
            o = (w[15:8] != 8'h00);
         end
         2'b01: r = d >> a;
         2'b10: r = $signed(d) >>> a;
         default: begin
            w = {d, d} << a;
            r = w[15:8];
         end
      endcase
   endtask

   task automatic do_op(input int sel, input logic [7:0] d,
                        input logic [2:0] a, input logic [1:0] m,
                        input logic [7:0] ed, input int ee,
                        input logic eo);
      int   n;
      exp_t e;
      n = 0;
      while (!rdy(sel) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("in_ready_pre", 32'(rdy(sel)), 1);
      in_data = d;
      in_amt  = a;
      in_mode = m;
      if (sel == 1) in_valid1 = 1'b1;
      else          in_valid0 = 1'b1;
      e.data  = ed;
      e.ovf   = eo;
      e.edges = ee;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      in_data   = ~d;
      in_amt    = ~a;
      in_mode   = ~m;
      n = 1;
      while (!ov(sel) && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      e = sb.pop_front();
      chk("out_valid", 32'(ov(sel)), 1);
      chk("latency", n, e.edges);
      chk("out_data", 32'(od(sel)), 32'(e.data));
`ifdef SHIFT_OVF_EN
      chk("out_ovf", 32'(oo(sel)), 32'(e.ovf));
`endif
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("in_ready_post", 32'(rdy(sel)), 1);
      chk("out_valid_drop", 32'(ov(sel)), 0);
   endtask

   initial begin
      logic [7:0] r;
      logic       o;
      logic [2:0] a;
      logic [1:0] m;
      logic [7:0] d;
      int         s;

      vecs[0]  = '{0, 8'h5A, 3'd1, 2'b00, 8'hB4, 2, 1'b0};
      vecs[1]  = '{0, 8'h96, 3'd3, 2'b10, 8'hF2, 4, 1'b0};
      vecs[2]  = '{0, 8'h5A, 3'd4, 2'b01, 8'h05, 5, 1'b0};
      vecs[3]  = '{1, 8'h81, 3'd4, 2'b11, 8'h18, 3, 1'b0};
      vecs[4]  = '{1, 8'h81, 3'd3, 2'b11, 8'h0C, 3, 1'b0};
      vecs[5]  = '{0, 8'hC3, 3'd0, 2'b00, 8'hC3, 1, 1'b0};
      vecs[6]  = '{0, 8'h5A, 3'd2, 2'b00, 8'h68, 3, 1'b1};
      vecs[7]  = '{0, 8'h1A, 3'd2, 2'b00, 8'h68, 3, 1'b0};
      vecs[8]  = '{0, 8'hFF, 3'd3, 2'b01, 8'h1F, 4, 1'b0};
      vecs[9]  = '{0, 8'h81, 3'd7, 2'b11, 8'hC0, 8, 1'b0};
      vecs[10] = '{1, 8'h7F, 3'd7, 2'b10, 8'h00, 5, 1'b0};
      vecs[11] = '{0, 8'h80, 3'd7, 2'b01, 8'h01, 8, 1'b0};
      vecs[12] = '{1, 8'h80, 3'd7, 2'b10, 8'hFF, 5, 1'b0};
      vecs[13] = '{1, 8'hFF, 3'd7, 2'b00, 8'h80, 5, 1'b1};

      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      in_data   = 8'h00;
      in_amt    = 3'd0;
      in_mode   = 2'b00;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready0", 32'(in_ready0), 1);
      chk("rst_in_ready1", 32'(in_ready1), 1);
      chk("rst_out_valid0", 32'(out_valid0), 0);
      chk("rst_out_valid1", 32'(out_valid1), 0);
      chk("rst_out_data0", 32'(out_data0), 0);
      chk("rst_out_data1", 32'(out_data1), 0);
`ifdef SHIFT_OVF_EN
      chk("rst_out_ovf0", 32'(out_ovf0), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i].sel, vecs[i].data, vecs[i].amt, vecs[i].mode,
               vecs[i].exp, vecs[i].edges, vecs[i].ovf);
      end

      for (int i = 0; i < 16; i++) begin
         s = i % 2;
         d = 8'($urandom);
         a = 3'($urandom_range(0, 7));
         m = 2'($urandom_range(0, 3));
         model(d, a, m, r, o);
         do_op(s, d, a, m, r, 1 + (int'(a) + s) / (s + 1), o);
      end

      // amt=0 result held under backpressure; new operand refused
      in_data   = 8'hC3;
      in_amt    = 3'd0;
      in_mode   = 2'b00;
      in_valid0 = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid0), 1);
      in_data = 8'h3C;
      in_amt  = 3'd5;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_data", 32'(out_data0), 32'hC3);
         chk("bp_in_ready", 32'(in_ready0), 0);
         chk("bp_out_valid", 32'(out_valid0), 1);
      end
      in_valid0 = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release", 32'(in_ready0), 1);
      chk("bp_not_taken", 32'(out_valid0), 0);

      // reset in the third SHIFT cycle aborts with no partial result
      in_data   = 8'h81;
      in_amt    = 3'd7;
      in_mode   = 2'b11;
      in_valid0 = 1'b1;
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("mid_busy", 32'(in_ready0), 0);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid0), 0);
      chk("abort_data", 32'(out_data0), 0);
      chk("abort_ready", 32'(in_ready0), 1);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(0, 8'h5A, 3'd1, 2'b00, 8'hB4, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
